// File: rtl/fetch_flush_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_flush_sequencer_if
// Purpose  : Redirect-event, credit and recovery-control bundle between the
//            fetch/decode front end and the flush sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface fetch_flush_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_IDX_W  = 5
);
  logic [2:0]            mispredict_valid_i;
  logic [DATA_WIDTH-1:0] mispredict_pc_i_0;
  logic [DATA_WIDTH-1:0] mispredict_pc_i_1;
  logic [DATA_WIDTH-1:0] mispredict_pc_i_2;
  logic [ROB_IDX_W-1:0]  mispredict_rob_i_0;
  logic [ROB_IDX_W-1:0]  mispredict_rob_i_1;
  logic [ROB_IDX_W-1:0]  mispredict_rob_i_2;
  logic                  exception_valid_i;
  logic [DATA_WIDTH-1:0] exception_pc_i;
  logic [ROB_IDX_W-1:0]  rob_head_i;
  logic [2:0]            dispatch_credit_i;
  logic                  buffer_empty_i;
  logic                  flush_o;
  logic                  fetch_stall_o;
  logic                  redirect_valid_o;
  logic [DATA_WIDTH-1:0] redirect_pc_o;
  logic [2:0]            decode_ready_o;
  logic [1:0]            state_o;
  logic [15:0]           flush_count_o;

  // Environment side: produces events/credits, consumes recovery control.
  modport master (
    output mispredict_valid_i, mispredict_pc_i_0, mispredict_pc_i_1, mispredict_pc_i_2,
    output mispredict_rob_i_0, mispredict_rob_i_1, mispredict_rob_i_2,
    output exception_valid_i, exception_pc_i, rob_head_i, dispatch_credit_i, buffer_empty_i,
    input  flush_o, fetch_stall_o, redirect_valid_o, redirect_pc_o, decode_ready_o,
    input  state_o, flush_count_o
  );

  // Sequencer side.
  modport slave (
    input  mispredict_valid_i, mispredict_pc_i_0, mispredict_pc_i_1, mispredict_pc_i_2,
    input  mispredict_rob_i_0, mispredict_rob_i_1, mispredict_rob_i_2,
    input  exception_valid_i, exception_pc_i, rob_head_i, dispatch_credit_i, buffer_empty_i,
    output flush_o, fetch_stall_o, redirect_valid_o, redirect_pc_o, decode_ready_o,
    output state_o, flush_count_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_flush_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_flush_sequencer
// Purpose  : Picks the oldest redirect event (exception or one of three
//            mispredicts), sequences flush -> redirect -> refill -> run, and
//            produces the contiguous per-lane decode_ready mask in RUN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fetch_flush_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_IDX_W    = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  fetch_flush_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_REFILL   = 2'd3;

  // What the latched redirect refers to; its age is recomputed from this.
  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_MISP = 2'd1;
  localparam logic [1:0] KIND_EXC  = 2'd2;

  localparam logic [3:0]  CNT_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            kind_q, kind_d;
  logic [ROB_IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           count_q, count_d;
  logic                  flush_q, stall_q, redir_q;

  logic [DATA_WIDTH-1:0] lane_pc  [3];
  logic [ROB_IDX_W-1:0]  lane_rob [3];
  logic [ROB_IDX_W-1:0]  lane_age [3];

  logic                  pick_found;
  logic [ROB_IDX_W-1:0]  pick_age;
  logic [ROB_IDX_W-1:0]  pick_idx;
  logic [DATA_WIDTH-1:0] pick_pc;

  logic                  event_w;
  logic [ROB_IDX_W-1:0]  cand_age;
  logic [DATA_WIDTH-1:0] cand_pc;
  logic [ROB_IDX_W-1:0]  lat_age;
  logic                  take_w;
  logic [2:0]            c;

  assign lane_pc[0]  = bus.mispredict_pc_i_0;
  assign lane_pc[1]  = bus.mispredict_pc_i_1;
  assign lane_pc[2]  = bus.mispredict_pc_i_2;
  assign lane_rob[0] = bus.mispredict_rob_i_0;
  assign lane_rob[1] = bus.mispredict_rob_i_1;
  assign lane_rob[2] = bus.mispredict_rob_i_2;

  // Age relative to the live ROB head; wraps naturally at 2**ROB_IDX_W.
  for (genvar g = 0; g < 3; g++) begin : g_lane
    assign lane_age[g] = lane_rob[g] - bus.rob_head_i;
  end

  // Oldest valid mispredict; strict compare keeps ties on the lower lane.
  always_comb begin
    pick_found = 1'b0;
    pick_age   = '1;
    pick_idx   = '0;
    pick_pc    = '0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mispredict_valid_i[i] && (!pick_found || (lane_age[i] < pick_age))) begin
        pick_found = 1'b1;
        pick_age   = lane_age[i];
        pick_idx   = lane_rob[i];
        pick_pc    = lane_pc[i];
      end
    end
  end

  assign event_w  = bus.exception_valid_i | (|bus.mispredict_valid_i);
  assign cand_age = bus.exception_valid_i ? '0 : pick_age;
  assign cand_pc  = bus.exception_valid_i ? bus.exception_pc_i : pick_pc;

  // Age of the redirect currently being recovered, against today's head.
  always_comb begin
    case (kind_q)
      KIND_EXC:  lat_age = '0;
      KIND_MISP: lat_age = idx_q - bus.rob_head_i;
      default:   lat_age = '1;
    endcase
  end

  // Any event starts a recovery from RUN; mid-recovery only an older one does.
  assign take_w = event_w && ((state_q == ST_RUN) || (cand_age < lat_age));

  // Next-state logic for the recovery sequence and the latched redirect.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (take_w) begin
      state_d = ST_FLUSH;
      cnt_d   = CNT_INIT;
      kind_d  = bus.exception_valid_i ? KIND_EXC : KIND_MISP;
      idx_d   = pick_idx;
      pc_d    = cand_pc;
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 16'd1;
      end
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_REDIRECT;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_REDIRECT: state_d = ST_REFILL;
        ST_REFILL: begin
          if (!bus.buffer_empty_i) begin
            state_d = ST_RUN;
            kind_d  = KIND_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, latched redirect and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      kind_q  <= KIND_NONE;
      idx_q   <= '0;
      pc_q    <= '0;
      count_q <= 16'd0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      flush_q <= (state_d == ST_FLUSH);
      stall_q <= (state_d == ST_FLUSH);
      redir_q <= (state_d == ST_REDIRECT);
    end
  end

  assign c = bus.dispatch_credit_i;

  assign bus.decode_ready_o   = ((state_q == ST_RUN) && !event_w) ?
                                {c[0] & c[1] & c[2], c[0] & c[1], c[0]} : 3'b000;
  assign bus.flush_o          = flush_q;
  assign bus.fetch_stall_o    = stall_q;
  assign bus.redirect_valid_o = redir_q;
  assign bus.redirect_pc_o    = pc_q;
  assign bus.state_o          = state_q;
  assign bus.flush_count_o    = count_q;

endmodule
`default_nettype wire
